// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small synchronous FIFO.
// Producers push words with a valid/ready handshake; the FSM pops them and
// serialises each one LSB-first as start, data, optional parity and stop bits,
// chaining frames with no idle gap while the FIFO holds data.
//
// Ports:
//   Clk_i    - system clock, single domain
//   Reset_i  - synchronous, active-high reset
//   Data_i   - word to transmit (data_bits_p wide)
//   Valid_i  - Data_i is valid; accepted when Ready_o is also high
//   Ready_o  - FIFO not full
//   Tx_o     - serial line, idles high, driven from a register
//   Busy_o   - a frame is in progress (START/DATA/PARITY/STOP)
//   Level_o  - number of occupied FIFO entries
module uart_tx_fifo #(
  parameter int unsigned baud_div_p   = 5208,
  parameter int unsigned data_bits_p  = 8,
  parameter int unsigned parity_p     = 0,
  parameter int unsigned stop_bits_p  = 1,
  parameter int unsigned fifo_depth_p = 16,
  parameter int unsigned level_w_p    = 5
) (
  input  logic                   Clk_i,
  input  logic                   Reset_i,
  input  logic [data_bits_p-1:0] Data_i,
  input  logic                   Valid_i,
  output logic                   Ready_o,
  output logic                   Tx_o,
  output logic                   Busy_o,
  output logic [level_w_p-1:0]   Level_o
);

  localparam int unsigned cnt_w_lp = $clog2(baud_div_p);
  localparam int unsigned bit_w_lp = $clog2(data_bits_p);
  localparam int unsigned ptr_w_lp = $clog2(fifo_depth_p);

  typedef enum logic [2:0] {
    st_idle   = 3'd0,
    st_start  = 3'd1,
    st_data   = 3'd2,
    st_parity = 3'd3,
    st_stop   = 3'd4
  } state_e;

  // ---------------------------------------------------------------------------
  // FIFO storage and occupancy
  // ---------------------------------------------------------------------------
  logic [data_bits_p-1:0] mem_q [fifo_depth_p];
  logic [ptr_w_lp-1:0]    wr_ptr_q;
  logic [ptr_w_lp-1:0]    rd_ptr_q;
  logic [level_w_p-1:0]   level_q;
  logic [level_w_p-1:0]   level_d;
  logic                   ready_q;
  logic                   push;
  logic                   pop;
  logic                   fifo_nonempty;
  logic [data_bits_p-1:0] head;
  logic                   head_par;

  assign push          = Valid_i & ready_q;
  assign fifo_nonempty = (level_q != '0);
  assign head          = mem_q[rd_ptr_q];

  // Parity of the word at the head, latched alongside it on pop
  always_comb begin
    head_par = ^head;
    if (parity_p == 1) begin
      head_par = ~^head;
    end
  end

  // Next occupancy: a simultaneous push and pop leaves it unchanged
  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + level_w_p'(1);
      2'b01:   level_d = level_q - level_w_p'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointers wrap naturally: depth is a power of two
  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + ptr_w_lp'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + ptr_w_lp'(1);
      end
      level_q <= level_d;
      // Ready is precomputed from the next level so it comes straight off a flop
      ready_q <= (level_d != level_w_p'(fifo_depth_p));
    end
  end

  // Storage array needs no reset; occupancy tracks validity
  always_ff @(posedge Clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= Data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_e                 state_q;
  state_e                 state_d;
  logic [cnt_w_lp-1:0]    cnt_q;
  logic [cnt_w_lp-1:0]    cnt_d;
  logic [bit_w_lp-1:0]    bit_q;
  logic [bit_w_lp-1:0]    bit_d;
  logic [data_bits_p-1:0] shift_q;
  logic [data_bits_p-1:0] shift_d;
  logic                   par_q;
  logic                   par_d;
  logic                   tx_q;
  logic                   tx_d;
  logic                   busy_q;
  logic                   baud_done;

  assign baud_done = (cnt_q == cnt_w_lp'(baud_div_p - 1));

  // State register; Tx and Busy are registered from the next-state values
  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      state_q <= st_idle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != st_idle);
    end
  end

  // Next-state, pop request and next line value
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + cnt_w_lp'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    pop     = 1'b0;

    unique case (state_q)
      st_idle: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        pop   = fifo_nonempty;
      end

      st_start: begin
        if (baud_done) begin
          state_d = st_data;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end

      st_data: begin
        if (baud_done) begin
          cnt_d = '0;
          if (bit_q == bit_w_lp'(data_bits_p - 1)) begin
            bit_d = '0;
            if (parity_p != 0) begin
              state_d = st_parity;
              tx_d    = par_q;
            end else begin
              state_d = st_stop;
              tx_d    = 1'b1;
            end
          end else begin
            // Shift right so the next data bit is always at index 0
            bit_d   = bit_q + bit_w_lp'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end

      st_parity: begin
        if (baud_done) begin
          state_d = st_stop;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end

      st_stop: begin
        if (baud_done) begin
          cnt_d = '0;
          if (bit_q == bit_w_lp'(stop_bits_p - 1)) begin
            if (fifo_nonempty) begin
              pop = 1'b1;
            end else begin
              state_d = st_idle;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + bit_w_lp'(1);
          end
        end
      end

      default: begin
        state_d = st_idle;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase

    // Popping loads the head word and starts a frame, from IDLE or end of STOP
    if (pop) begin
      state_d = st_start;
      cnt_d   = '0;
      bit_d   = '0;
      shift_d = head;
      par_d   = head_par;
      tx_d    = 1'b0;
    end
  end

  assign Ready_o = ready_q;
  assign Tx_o    = tx_q;
  assign Busy_o  = busy_q;
  assign Level_o = level_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: four instances with different parameter sets
// share one clock. Words are pushed to a scoreboard when driven into a DUT and
// popped when the matching frame is captured on the serial line.
module tb_uart_tx_fifo;

  logic       clk;
  logic [3:0] rst_v;
  logic [3:0] vld_v;
  logic [7:0] dat_a, dat_b, dat_c;
  logic [4:0] dat_d;
  logic       tx0, tx1, tx2, tx3;
  logic       rdy0, rdy1, rdy2, rdy3;
  logic       busy0, busy1, busy2, busy3;
  logic [2:0] lvl_a, lvl_b, lvl_c;
  logic [1:0] lvl_d;
  logic [3:0] tx_v, busy_v;

  assign tx_v   = {tx3, tx2, tx1, tx0};
  assign busy_v = {busy3, busy2, busy1, busy0};

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [8:0] sb_q[$];

  // 8N1, depth 4
  uart_tx_fifo #(.baud_div_p(4), .data_bits_p(8), .parity_p(0), .stop_bits_p(1),
                 .fifo_depth_p(4), .level_w_p(3)) u_a (
    .Clk_i(clk), .Reset_i(rst_v[0]), .Data_i(dat_a), .Valid_i(vld_v[0]),
    .Ready_o(rdy0), .Tx_o(tx0), .Busy_o(busy0), .Level_o(lvl_a));

  // 8E2
  uart_tx_fifo #(.baud_div_p(4), .data_bits_p(8), .parity_p(2), .stop_bits_p(2),
                 .fifo_depth_p(4), .level_w_p(3)) u_b (
    .Clk_i(clk), .Reset_i(rst_v[1]), .Data_i(dat_b), .Valid_i(vld_v[1]),
    .Ready_o(rdy1), .Tx_o(tx1), .Busy_o(busy1), .Level_o(lvl_b));

  // 8O2
  uart_tx_fifo #(.baud_div_p(4), .data_bits_p(8), .parity_p(1), .stop_bits_p(2),
                 .fifo_depth_p(4), .level_w_p(3)) u_c (
    .Clk_i(clk), .Reset_i(rst_v[2]), .Data_i(dat_c), .Valid_i(vld_v[2]),
    .Ready_o(rdy2), .Tx_o(tx2), .Busy_o(busy2), .Level_o(lvl_c));

  // 5N1, depth 2
  uart_tx_fifo #(.baud_div_p(4), .data_bits_p(5), .parity_p(0), .stop_bits_p(1),
                 .fifo_depth_p(2), .level_w_p(2)) u_d (
    .Clk_i(clk), .Reset_i(rst_v[3]), .Data_i(dat_d), .Valid_i(vld_v[3]),
    .Ready_o(rdy3), .Tx_o(tx3), .Busy_o(busy3), .Level_o(lvl_d));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference waveform: one entry per clock, baud 4, cycle 0 = first start cycle
  function automatic logic [47:0] exp_wave(input logic [8:0] w, input int nbits,
                                           input int par, input int nstop);
    logic [47:0] e;
    logic        p;
    int          k;
    e = '0;
    p = 1'b0;
    for (int i = 0; i < nbits; i++) p = p ^ w[i];
    if (par == 1) p = ~p;
    k = 4;
    for (int i = 0; i < nbits; i++)
      for (int j = 0; j < 4; j++) begin e[k] = w[i]; k++; end
    if (par != 0)
      for (int j = 0; j < 4; j++) begin e[k] = p; k++; end
    for (int j = 0; j < 4 * nstop; j++) begin e[k] = 1'b1; k++; end
    return e;
  endfunction

  // Wait for a start bit on DUT d (bounded), then record len cycles of Tx.
  // waited = number of negedges to reach the start bit, -1 on timeout.
  task automatic rx_frame(input int d, input int len, input int budget,
                          output logic [47:0] obs, output int waited,
                          output int busy_lows);
    obs = '0;
    waited = 0;
    busy_lows = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (tx_v[d] !== 1'b0 && waited < budget);
    if (tx_v[d] !== 1'b0) begin
      waited = -1;
      return;
    end
    obs[0] = tx_v[d];
    if (busy_v[d] !== 1'b1) busy_lows++;
    for (int i = 1; i < len; i++) begin
      @(negedge clk);
      obs[i] = tx_v[d];
      if (busy_v[d] !== 1'b1) busy_lows++;
    end
  endtask

  task automatic sb_next(output logic [8:0] w);
    if (sb_q.size() != 0) w = sb_q.pop_front();
    else w = 'x;
  endtask

  // Single write on instance A; caller is just after a rising edge
  task automatic put_a(input logic [7:0] w);
    vld_v[0] = 1'b1;
    dat_a = w;
    sb_q.push_back({1'b0, w});
    @(posedge clk); #1;
    vld_v[0] = 1'b0;
  endtask

  task automatic test_reset();
    rst_v = 4'hF; vld_v = 4'h0;
    dat_a = '0; dat_b = '0; dat_c = '0; dat_d = '0;
    repeat (2) @(posedge clk);
    #1 rst_v = 4'h0;
    @(negedge clk);
    vec_cnt++; if (tx0 !== 1'b1) begin err_cnt++; $display("FAIL reset_tx got=%b exp=1", tx0); end
    vec_cnt++; if (busy0 !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got=%b exp=0", busy0); end
    vec_cnt++; if (lvl_a !== 3'd0) begin err_cnt++; $display("FAIL reset_level got=%0d exp=0", lvl_a); end
    vec_cnt++; if (rdy0 !== 1'b1) begin err_cnt++; $display("FAIL reset_ready got=%b exp=1", rdy0); end
    vec_cnt++; if ({tx3, tx2, tx1} !== 3'b111) begin err_cnt++; $display("FAIL reset_tx_others got=%b exp=111", {tx3, tx2, tx1}); end
    vec_cnt++; if ({rdy3, lvl_d} !== 3'b100) begin err_cnt++; $display("FAIL reset_d got=%b exp=100", {rdy3, lvl_d}); end
  endtask

  task automatic test_single();
    logic [47:0] obs;
    logic [8:0]  w;
    int          waited, bl;
    @(posedge clk); #1;
    put_a(8'hA5);
    @(negedge clk);
    vec_cnt++; if (lvl_a !== 3'd1) begin err_cnt++; $display("FAIL single_level_after_write got=%0d exp=1", lvl_a); end
    vec_cnt++; if (tx0 !== 1'b1) begin err_cnt++; $display("FAIL single_tx_before_pop got=%b exp=1", tx0); end
    rx_frame(0, 40, 20, obs, waited, bl);
    sb_next(w);
    vec_cnt++; if (waited !== 1) begin err_cnt++; $display("FAIL single_latency got=%0d exp=1", waited); end
    vec_cnt++; if (obs !== exp_wave(w, 8, 0, 1)) begin err_cnt++; $display("FAIL single_wave got=%h exp=%h", obs, exp_wave(w, 8, 0, 1)); end
    vec_cnt++; if (bl !== 0) begin err_cnt++; $display("FAIL single_busy_in_frame got=%0d lows exp=0", bl); end
    @(negedge clk);
    vec_cnt++; if ({busy0, tx0, lvl_a} !== 5'b01000) begin err_cnt++; $display("FAIL single_after_frame got=%b exp=01000", {busy0, tx0, lvl_a}); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3];
    words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hFF;
    @(posedge clk); #1;
    fork
      begin
        vld_v[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
          dat_a = words[i];
          sb_q.push_back({1'b0, words[i]});
          @(posedge clk); #1;
        end
        vld_v[0] = 1'b0;
      end
      begin
        logic [47:0] obs;
        logic [8:0]  w;
        int          waited, bl;
        for (int f = 0; f < 3; f++) begin
          rx_frame(0, 40, (f == 0) ? 10 : 2, obs, waited, bl);
          sb_next(w);
          vec_cnt++; if (obs !== exp_wave(w, 8, 0, 1)) begin err_cnt++; $display("FAIL b2b_wave%0d got=%h exp=%h", f, obs, exp_wave(w, 8, 0, 1)); end
          vec_cnt++; if (bl !== 0) begin err_cnt++; $display("FAIL b2b_busy%0d got=%0d lows exp=0", f, bl); end
          if (f > 0) begin
            vec_cnt++; if (waited !== 1) begin err_cnt++; $display("FAIL b2b_gap%0d got=%0d exp=1", f, waited); end
          end
        end
      end
    join
    @(negedge clk);
    vec_cnt++; if ({busy0, tx0} !== 2'b01) begin err_cnt++; $display("FAIL b2b_end got=%b exp=01", {busy0, tx0}); end
  endtask

  task automatic test_overflow();
    @(posedge clk); #1;
    fork
      begin
        put_a(8'h11);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
          vld_v[0] = 1'b1;
          dat_a = 8'hC0 | 8'(i);
          vec_cnt++; if (rdy0 !== (i < 4)) begin err_cnt++; $display("FAIL ovf_ready%0d got=%b exp=%b", i, rdy0, (i < 4)); end
          vec_cnt++; if (lvl_a !== 3'((i < 4) ? i : 4)) begin err_cnt++; $display("FAIL ovf_level%0d got=%0d exp=%0d", i, lvl_a, (i < 4) ? i : 4); end
          if (i < 4) sb_q.push_back({1'b0, 8'hC0 | 8'(i)});
          @(posedge clk); #1;
        end
        vld_v[0] = 1'b0;
        vec_cnt++; if ({rdy0, lvl_a} !== 4'b0100) begin err_cnt++; $display("FAIL ovf_full got=%b exp=0100", {rdy0, lvl_a}); end
      end
      begin
        logic [47:0] obs;
        logic [8:0]  w;
        int          waited, bl;
        for (int f = 0; f < 5; f++) begin
          rx_frame(0, 40, (f == 0) ? 10 : 2, obs, waited, bl);
          sb_next(w);
          vec_cnt++; if (obs !== exp_wave(w, 8, 0, 1)) begin err_cnt++; $display("FAIL ovf_wave%0d got=%h exp=%h", f, obs, exp_wave(w, 8, 0, 1)); end
        end
        rx_frame(0, 40, 50, obs, waited, bl);
        vec_cnt++; if (waited !== -1) begin err_cnt++; $display("FAIL ovf_extra_frame got=%0d exp=-1", waited); end
        vec_cnt++; if (sb_q.size() !== 0) begin err_cnt++; $display("FAIL ovf_sb_left got=%0d exp=0", sb_q.size()); end
      end
    join
  endtask

  task automatic test_reset_mid();
    logic [47:0] obs;
    logic [8:0]  w;
    logic [7:0]  w0;
    int          waited, bl;
    w0 = 8'h5A;
    @(posedge clk); #1;
    vld_v[0] = 1'b1;
    dat_a = w0;
    @(posedge clk); #1;
    dat_a = 8'h99;
    @(posedge clk); #1;
    vld_v[0] = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    vec_cnt++; if (tx0 !== w0[3]) begin err_cnt++; $display("FAIL rst_mid_bit3 got=%b exp=%b", tx0, w0[3]); end
    vec_cnt++; if ({busy0, lvl_a} !== 4'b1001) begin err_cnt++; $display("FAIL rst_mid_pre got=%b exp=1001", {busy0, lvl_a}); end
    rst_v[0] = 1'b1;
    @(posedge clk); #1;
    rst_v[0] = 1'b0;
    vec_cnt++; if ({tx0, busy0, lvl_a, rdy0} !== 6'b100001) begin err_cnt++; $display("FAIL rst_mid_post got=%b exp=100001", {tx0, busy0, lvl_a, rdy0}); end
    sb_q.delete();
    rx_frame(0, 40, 12, obs, waited, bl);
    vec_cnt++; if (waited !== -1) begin err_cnt++; $display("FAIL rst_mid_resume got=%0d exp=-1", waited); end
    @(posedge clk); #1;
    put_a(8'h3C);
    @(negedge clk);
    rx_frame(0, 40, 20, obs, waited, bl);
    sb_next(w);
    vec_cnt++; if (waited !== 1) begin err_cnt++; $display("FAIL rst_mid_latency got=%0d exp=1", waited); end
    vec_cnt++; if (obs !== exp_wave(w, 8, 0, 1)) begin err_cnt++; $display("FAIL rst_mid_wave got=%h exp=%h", obs, exp_wave(w, 8, 0, 1)); end
  endtask

  task automatic test_parity();
    logic [47:0] obs;
    logic [8:0]  w;
    int          waited, bl;
    // Even parity, two stop bits
    @(posedge clk); #1;
    vld_v[1] = 1'b1; dat_b = 8'h07; sb_q.push_back(9'h007);
    @(posedge clk); #1;
    vld_v[1] = 1'b0;
    rx_frame(1, 48, 5, obs, waited, bl);
    sb_next(w);
    vec_cnt++; if (waited !== 2) begin err_cnt++; $display("FAIL even_latency got=%0d exp=2", waited); end
    vec_cnt++; if (obs !== exp_wave(w, 8, 2, 2)) begin err_cnt++; $display("FAIL even_wave got=%h exp=%h", obs, exp_wave(w, 8, 2, 2)); end
    vec_cnt++; if (obs[37] !== 1'b1) begin err_cnt++; $display("FAIL even_parity_bit got=%b exp=1", obs[37]); end
    vec_cnt++; if (obs[47:40] !== 8'hFF) begin err_cnt++; $display("FAIL even_stop got=%h exp=ff", obs[47:40]); end
    vec_cnt++; if (bl !== 0) begin err_cnt++; $display("FAIL even_busy got=%0d lows exp=0", bl); end
    @(negedge clk);
    vec_cnt++; if ({busy1, tx1, lvl_b} !== 5'b01000) begin err_cnt++; $display("FAIL even_end got=%b exp=01000", {busy1, tx1, lvl_b}); end
    // Odd parity
    @(posedge clk); #1;
    vld_v[2] = 1'b1; dat_c = 8'h07; sb_q.push_back(9'h007);
    @(posedge clk); #1;
    vld_v[2] = 1'b0;
    rx_frame(2, 48, 5, obs, waited, bl);
    sb_next(w);
    vec_cnt++; if (obs !== exp_wave(w, 8, 1, 2)) begin err_cnt++; $display("FAIL odd_wave got=%h exp=%h", obs, exp_wave(w, 8, 1, 2)); end
    vec_cnt++; if (obs[37] !== 1'b0) begin err_cnt++; $display("FAIL odd_parity_bit got=%b exp=0", obs[37]); end
    @(negedge clk);
    vec_cnt++; if ({busy2, tx2, lvl_c} !== 5'b01000) begin err_cnt++; $display("FAIL odd_end got=%b exp=01000", {busy2, tx2, lvl_c}); end
  endtask

  task automatic test_wrap();
    logic [4:0] words [10];
    for (int k = 0; k < 10; k++) words[k] = 5'((k * 7 + 3) % 32);
    @(posedge clk); #1;
    fork
      begin
        int n;
        vld_v[3] = 1'b1;
        dat_d = words[0];
        vec_cnt++; if ({rdy3, lvl_d} !== 3'b100) begin err_cnt++; $display("FAIL wrap_start got=%b exp=100", {rdy3, lvl_d}); end
        @(posedge clk); #1;
        sb_q.push_back({4'b0, words[0]});
        dat_d = words[1];
        vec_cnt++; if ({rdy3, lvl_d} !== 3'b101) begin err_cnt++; $display("FAIL wrap_first got=%b exp=101", {rdy3, lvl_d}); end
        @(posedge clk); #1;
        sb_q.push_back({4'b0, words[1]});
        dat_d = words[2];
        vec_cnt++; if ({rdy3, lvl_d} !== 3'b101) begin err_cnt++; $display("FAIL wrap_push_pop got=%b exp=101", {rdy3, lvl_d}); end
        @(posedge clk); #1;
        sb_q.push_back({4'b0, words[2]});
        vec_cnt++; if ({rdy3, lvl_d} !== 3'b010) begin err_cnt++; $display("FAIL wrap_full got=%b exp=010", {rdy3, lvl_d}); end
        for (int k = 3; k < 10; k++) begin
          dat_d = words[k];
          n = 0;
          while (rdy3 !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
          end
          vec_cnt++; if (rdy3 !== 1'b1) begin err_cnt++; $display("FAIL wrap_ready_timeout%0d got=%b exp=1", k, rdy3); end
          @(posedge clk); #1;
          sb_q.push_back({4'b0, words[k]});
        end
        vld_v[3] = 1'b0;
      end
      begin
        logic [47:0] obs;
        logic [8:0]  w;
        int          waited, bl;
        for (int f = 0; f < 10; f++) begin
          rx_frame(3, 28, (f == 0) ? 10 : 2, obs, waited, bl);
          sb_next(w);
          vec_cnt++; if (obs !== exp_wave(w, 5, 0, 1)) begin err_cnt++; $display("FAIL wrap_wave%0d got=%h exp=%h", f, obs, exp_wave(w, 5, 0, 1)); end
        end
      end
    join
    @(negedge clk);
    vec_cnt++; if ({busy3, lvl_d} !== 3'b000) begin err_cnt++; $display("FAIL wrap_end got=%b exp=000", {busy3, lvl_d}); end
    vec_cnt++; if (sb_q.size() !== 0) begin err_cnt++; $display("FAIL wrap_sb_left got=%0d exp=0", sb_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_parity();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
